// File: rtl/clk_lock_supervisor_pkg.sv
// clk_lock_supervisor_pkg: state encoding and frequency-window helper for clk_lock_supervisor
package clk_lock_supervisor_pkg;
  typedef enum logic [2:0] {WAIT_LOCK, STABILIZE, CHECK_FREQ, RUN, FAULT} state_t;
  function automatic logic in_window(input int unsigned count, input int unsigned exp_c, input int unsigned tol);
    return (count + tol >= exp_c) && (count <= exp_c + tol);
  endfunction
endpackage

// File: rtl/sync_ff.sv
// sync_ff: STAGES-deep async-reset synchroniser for a single asynchronous bit
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] r;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r <= '0;
    else r <= {r[STAGES-2:0], d};
  assign q = r[STAGES-1];
endmodule

// File: rtl/clk_lock_supervisor.sv
// clk_lock_supervisor: qualifies PLL lock before releasing reset/ready and counts lock losses.
// Define CLK_LOCK_SUPERVISOR_FREQ_CHECK_EN to add reference-toggle period checking and FAULT handling.
module clk_lock_supervisor
  import clk_lock_supervisor_pkg::*;
#(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned EXPECT_CYCLES      = 900,
  parameter int unsigned TOLERANCE          = 9,
  parameter int unsigned CHECK_PASSES       = 2,
  parameter int unsigned FAULT_HOLD_CYCLES  = 4096,
  parameter int unsigned RELOCK_CNT_W       = 8
) (
  input  logic                    in_clk,
  input  logic                    in_rst_n,
  input  logic                    in_lock,
  input  logic                    in_ref_toggle,
  output logic                    out_rst_n,
  output logic                    out_ready,
  output logic                    out_fault,
  output logic [RELOCK_CNT_W-1:0] out_relock_count
);
  localparam int STAB_W = $clog2(LOCK_STABLE_CYCLES) + 1;
  state_t state, after_stab;
  logic lock_s, freq_bad, freq_done, hold_done, freq_en;
  logic [STAB_W-1:0] stab_cnt;
  sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (.clk(in_clk), .rst_n(in_rst_n), .d(in_lock), .q(lock_s));
`ifdef CLK_LOCK_SUPERVISOR_FREQ_CHECK_EN
  localparam int unsigned PER_MAX = 2 * EXPECT_CYCLES;
  localparam int PER_W  = $clog2(PER_MAX) + 1;
  localparam int PASS_W = $clog2(CHECK_PASSES) + 1;
  localparam int HOLD_W = $clog2(FAULT_HOLD_CYCLES) + 1;
  logic tog_s, tog_q, edge_s, armed, timeout, per_ok, mon;
  logic [PER_W-1:0] per_cnt;
  logic [PASS_W-1:0] pass_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  sync_ff #(.STAGES(SYNC_STAGES)) u_tog_sync (.clk(in_clk), .rst_n(in_rst_n), .d(in_ref_toggle), .q(tog_s));
  assign edge_s     = tog_s ^ tog_q;
  assign mon        = (state == CHECK_FREQ) || (state == RUN);
  assign timeout    = per_cnt == PER_W'(PER_MAX);
  // count+1 because the edge cycle itself closes the measured interval
  assign per_ok     = in_window(32'(per_cnt) + 32'd1, EXPECT_CYCLES, TOLERANCE);
  assign freq_bad   = (edge_s && armed && !per_ok) || timeout;
  assign freq_done  = edge_s && armed && per_ok && (pass_cnt == PASS_W'(CHECK_PASSES - 1));
  assign hold_done  = hold_cnt == HOLD_W'(FAULT_HOLD_CYCLES - 1);
  assign after_stab = CHECK_FREQ;
  assign freq_en    = 1'b1;
  always_ff @(posedge in_clk or negedge in_rst_n)
    if (!in_rst_n) begin
      tog_q    <= 1'b0;
      armed    <= 1'b0;
      per_cnt  <= '0;
      pass_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      tog_q    <= tog_s;
      hold_cnt <= state == FAULT ? hold_cnt + 1'b1 : '0;
      if (!mon) begin
        armed    <= 1'b0;
        per_cnt  <= '0;
        pass_cnt <= '0;
      end else if (edge_s) begin
        armed   <= 1'b1;
        per_cnt <= '0;
        if (state == CHECK_FREQ && armed && per_ok) pass_cnt <= pass_cnt + 1'b1;
      end else if (!timeout) per_cnt <= per_cnt + 1'b1;
    end
`else
  logic unused_tog;
  assign unused_tog = in_ref_toggle;
  assign freq_bad   = 1'b0;
  assign freq_done  = 1'b0;
  assign hold_done  = 1'b1;
  assign after_stab = RUN;
  assign freq_en    = 1'b0;
`endif
  always_ff @(posedge in_clk or negedge in_rst_n)
    if (!in_rst_n) begin
      state            <= WAIT_LOCK;
      stab_cnt         <= '0;
      out_rst_n        <= 1'b0;
      out_ready        <= 1'b0;
      out_fault        <= 1'b0;
      out_relock_count <= '0;
    end else begin
      out_rst_n <= state == RUN;
      out_ready <= state == RUN;
      out_fault <= freq_en && state == FAULT;
      case (state)
        WAIT_LOCK: begin
          stab_cnt <= '0;
          if (lock_s) state <= STABILIZE;
        end
        STABILIZE:
          if (!lock_s) state <= WAIT_LOCK;
          else if (stab_cnt == STAB_W'(LOCK_STABLE_CYCLES - 1)) state <= after_stab;
          else stab_cnt <= stab_cnt + 1'b1;
        CHECK_FREQ:
          if (!lock_s) state <= WAIT_LOCK;
          else if (freq_bad) state <= FAULT;
          else if (freq_done) state <= RUN;
        RUN:
          if (!lock_s) begin
            state <= WAIT_LOCK;
            if (~&out_relock_count) out_relock_count <= out_relock_count + 1'b1;
          end else if (freq_bad) state <= FAULT;
        FAULT: if (hold_done) state <= WAIT_LOCK;
        default: state <= WAIT_LOCK;
      endcase
    end
endmodule
